wb_ctrl_pipe: RTL and testbench
===============================

Name: wb_ctrl_pipe

Overview:
Registered write-back stage controller for the MIPS-Lite/DLX pipeline. It decodes the destination register and write-back source from the MEM/WB instruction, waits for variable-latency load data, and drives a one-cycle register-file write. Loads of word, half and byte width are sign- or zero-extended. The block also exports pending-destination information to hazard logic. It sits between the MEM stage and the register file.

Parameters:
XLEN, 32, datapath width in bits (>=32, power of two)
RA_W, 5, register-address width
LINK_REG, 31, destination register for JAL
LOAD_TIMEOUT, 15, maximum wait cycles for load data before error (>=1)
CNT_W, 4, load-wait counter width (2**CNT_W > LOAD_TIMEOUT)

Ports:
CLK  in  1  clock, rising edge
RESET_N  in  1  asynchronous, active-low reset
in_valid  in  1  MEM stage presents an instruction
in_ready  out  1  stage can accept
IR  in  32  instruction
alu_res  in  XLEN  ALU result
link_pc  in  XLEN  link value (PC+8)
ld_addr_lo  in  2  low byte-address bits of the load
ld_valid  in  1  load data returned
ld_data  in  XLEN  raw load word
flush  in  1  kill any in-flight instruction
rf_we  out  1  register-file write strobe
rf_waddr  out  RA_W  write address
rf_wdata  out  XLEN  write data
pend_valid  out  1  a write is pending (state WAIT_LOAD)
pend_rd  out  RA_W  pending destination
ld_err  out  1  sticky load-timeout flag

Behaviour:
- Reset: state=IDLE; rf_we=0, rf_waddr=0, rf_wdata=0, pend_valid=0, pend_rd=0, ld_err=0, counter=0. in_ready=1 once reset is released.
- Destination decode:
  - LW/LH/LHU/LB/LBU and I-type ALU ops use rt=IR[20:16].
  - SPECIAL R-type and JALR use rd=IR[15:11].
  - JAL uses LINK_REG.
  - Stores, branches, J and all other opcodes use 0.
  - dest==0 never asserts rf_we.
- Source select:
  - load opcode selects LOAD.
  - JAL or SPECIAL+JALR selects LINK.
  - Everything else selects ALU.
- States:
  - IDLE: in_ready=1. On acceptance (in_valid && !flush):
    - Non-load: register dest and data. The next cycle has rf_we=(dest!=0) for exactly 1 cycle. Remain in IDLE. Back-to-back acceptance gives 1 write per cycle.
    - Load: capture dest, size, signedness and ld_addr_lo. Go to WAIT_LOAD with counter=0. pend_valid=1 and pend_rd=dest from the next cycle.
  - WAIT_LOAD: in_ready=0.
    - ld_valid: extract and extend the byte or half using ld_addr_lo (big-endian lane order; LW ignores ld_addr_lo). The next cycle has rf_we=(dest!=0) and rf_wdata=extended value. Go to IDLE; pend_valid falls in the same cycle rf_we rises.
    - No ld_valid: counter++. When counter==LOAD_TIMEOUT, set ld_err=1 (sticky until reset), commit nothing, and go to IDLE.
- ld_valid is ignored outside WAIT_LOAD.
- flush:
  - Highest priority. The same-cycle input is not accepted.
  - In WAIT_LOAD, return to IDLE without a write; a same-cycle ld_valid is discarded.
  - A registered write already due this cycle still occurs.
- Simultaneous ld_valid and timeout in one cycle: data wins; no error.
- Asynchronous reset mid-WAIT_LOAD: immediate return to the reset values above; no write.

Decomposition:
- Shared package/defs: opcode and function constants (LW, LH, LHU, LB, LBU, JAL, SPECIAL, JALR, I-type ALU ops), WB select encodings (select_wb_alu/load/link), state encoding.
- One sub-module, wb_load_align: combinational byte/half lane select plus sign/zero extension to XLEN.

Test Plan:
- ADD r3 (SPECIAL, rd=3), alu_res=0x1234 -> next cycle rf_we=1, rf_waddr=3, rf_wdata=0x1234; in_ready stays 1.
- JAL, link_pc=0x108 -> rf_waddr=31, rf_wdata=0x108. JALR rd=5 -> rf_waddr=5. SW -> rf_we stays 0.
- LB rt=7, ld_addr_lo=1, ld_valid 3 cycles later with ld_data=0x11F2_3344 -> pend_valid=1/pend_rd=7 while waiting; then rf_wdata=0xFFFF_FFF2. LBU with the same stimulus -> 0x0000_00F2.
- LW rt=0 -> no rf_we when data returns. ADDI rt=0 -> no rf_we.
- LW with no ld_valid -> after 15 wait cycles ld_err=1, no write, in_ready=1. A later LW with data still commits and ld_err stays 1.
- LW waiting, flush and ld_valid in the same cycle -> no write, IDLE next cycle. Assert RESET_N=0 mid-wait -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/wb_ctrl_pipe_pkg.sv
// Shared decode constants and encodings for the write-back controller.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package wb_ctrl_pipe_pkg;

   // Primary opcodes (IR[31:26])
   localparam logic [5:0] OP_SPECIAL = 6'h00;
   localparam logic [5:0] OP_JAL     = 6'h03;
   localparam logic [5:0] OP_ADDI    = 6'h08;   // first I-type ALU opcode
   localparam logic [5:0] OP_LUI     = 6'h0F;   // last I-type ALU opcode
   localparam logic [5:0] OP_LB      = 6'h20;
   localparam logic [5:0] OP_LH      = 6'h21;
   localparam logic [5:0] OP_LW      = 6'h23;
   localparam logic [5:0] OP_LBU     = 6'h24;
   localparam logic [5:0] OP_LHU     = 6'h25;

   // SPECIAL function codes (IR[5:0])
   localparam logic [5:0] FN_JALR    = 6'h09;

   typedef enum logic [1:0] {
      SELECT_WB_ALU  = 2'd0,
      SELECT_WB_LOAD = 2'd1,
      SELECT_WB_LINK = 2'd2
   } wb_sel_e;

   typedef enum logic [1:0] {
      LD_BYTE = 2'd0,
      LD_HALF = 2'd1,
      LD_WORD = 2'd2
   } ld_size_e;

   typedef enum logic {
      S_IDLE      = 1'b0,
      S_WAIT_LOAD = 1'b1
   } state_e;

   function automatic logic is_load(input logic [5:0] op);
      return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
             (op == OP_LBU) || (op == OP_LHU);
   endfunction

   function automatic logic is_itype_alu(input logic [5:0] op);
      return (op >= OP_ADDI) && (op <= OP_LUI);
   endfunction

endpackage

// File: rtl/wb_load_align.sv
// Load lane select (big-endian byte order) with sign/zero extension to XLEN.
// Latency: purely combinational.
// Backpressure: none.
module wb_load_align
   import wb_ctrl_pipe_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  ld_size_e         size_i,
   input  logic             unsigned_i,
   input  logic [1:0]       addr_lo_i,
   input  logic [XLEN-1:0]  data_i,
   output logic [XLEN-1:0]  data_o
);

   logic [31:0] word;
   logic [7:0]  b;
   logic [15:0] h;

   // Pick the addressed byte/half; byte address 0 lives in the most significant lane.
   always_comb begin
      word = data_i[31:0];
      case (addr_lo_i)
         2'd0:    b = word[31:24];
         2'd1:    b = word[23:16];
         2'd2:    b = word[15:8];
         default: b = word[7:0];
      endcase
      h = addr_lo_i[1] ? word[15:0] : word[31:16];
      case (size_i)
         LD_BYTE: data_o = unsigned_i ? XLEN'(b) : XLEN'($signed(b));
         LD_HALF: data_o = unsigned_i ? XLEN'(h) : XLEN'($signed(h));
         default: data_o = XLEN'($signed(word));
      endcase
   end

endmodule

// File: rtl/wb_ctrl_pipe.sv
// Write-back controller: decodes MEM/WB instruction, waits for load data, drives one RF write.
// Latency: ALU/link writes 1 cycle after acceptance; load writes 1 cycle after ld_valid.
// Backpressure: in_ready low while a load is outstanding; flush drops input and in-flight load.
module wb_ctrl_pipe
   import wb_ctrl_pipe_pkg::*;
#(
   parameter int XLEN         = 32,
   parameter int RA_W         = 5,
   parameter int LINK_REG     = 31,
   parameter int LOAD_TIMEOUT = 15,
   parameter int CNT_W        = 4
) (
   input  logic             CLK,
   input  logic             RESET_N,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      IR,
   input  logic [XLEN-1:0]  alu_res,
   input  logic [XLEN-1:0]  link_pc,
   input  logic [1:0]       ld_addr_lo,
   input  logic             ld_valid,
   input  logic [XLEN-1:0]  ld_data,
   input  logic             flush,
   output logic             rf_we,
   output logic [RA_W-1:0]  rf_waddr,
   output logic [XLEN-1:0]  rf_wdata,
   output logic             pend_valid,
   output logic [RA_W-1:0]  pend_rd,
   output logic             ld_err
);

   logic [5:0] op;
   logic [5:0] funct;
   assign op    = IR[31:26];
   assign funct = IR[5:0];

   // rs and shamt fields carry nothing this stage needs
   logic unused_ir_fields;
   assign unused_ir_fields = ^{IR[25:21], IR[10:6]};

   logic [RA_W-1:0] dec_dest;
   wb_sel_e         dec_sel;
   ld_size_e        dec_size;
   logic            dec_uns;

   state_e          state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
   logic [RA_W-1:0] ld_dest_q, ld_dest_d;
   ld_size_e        ld_size_q, ld_size_d;
   logic            ld_uns_q, ld_uns_d;
   logic [1:0]      ld_lo_q, ld_lo_d;
   logic            rf_we_q, rf_we_d;
   logic [RA_W-1:0] rf_waddr_q, rf_waddr_d;
   logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
   logic            ld_err_q, ld_err_d;
   logic [XLEN-1:0] ld_aligned;

   wb_load_align #(.XLEN(XLEN)) u_align (
      .size_i     (ld_size_q),
      .unsigned_i (ld_uns_q),
      .addr_lo_i  (ld_lo_q),
      .data_i     (ld_data),
      .data_o     (ld_aligned)
   );

   // Instruction decode: destination register, write-back source and load shape.
   always_comb begin
      dec_dest = '0;
      dec_sel  = SELECT_WB_ALU;
      dec_size = LD_WORD;
      dec_uns  = 1'b0;
      if (is_load(op)) begin
         dec_dest = RA_W'(IR[20:16]);
         dec_sel  = SELECT_WB_LOAD;
         if ((op == OP_LB) || (op == OP_LBU)) dec_size = LD_BYTE;
         if ((op == OP_LH) || (op == OP_LHU)) dec_size = LD_HALF;
         dec_uns  = (op == OP_LBU) || (op == OP_LHU);
      end else if (op == OP_JAL) begin
         dec_dest = RA_W'(LINK_REG);
         dec_sel  = SELECT_WB_LINK;
      end else if (op == OP_SPECIAL) begin
         dec_dest = RA_W'(IR[15:11]);
         if (funct == FN_JALR) dec_sel = SELECT_WB_LINK;
      end else if (is_itype_alu(op)) begin
         dec_dest = RA_W'(IR[20:16]);
      end
   end

   assign cnt_inc = cnt_q + CNT_W'(1);

   // Next-state logic: accept in IDLE, wait/timeout in WAIT_LOAD, flush overrides both.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      ld_dest_d  = ld_dest_q;
      ld_size_d  = ld_size_q;
      ld_uns_d   = ld_uns_q;
      ld_lo_d    = ld_lo_q;
      rf_we_d    = 1'b0;
      rf_waddr_d = rf_waddr_q;
      rf_wdata_d = rf_wdata_q;
      ld_err_d   = ld_err_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid && !flush) begin
               if (dec_sel == SELECT_WB_LOAD) begin
                  state_d   = S_WAIT_LOAD;
                  cnt_d     = '0;
                  ld_dest_d = dec_dest;
                  ld_size_d = dec_size;
                  ld_uns_d  = dec_uns;
                  ld_lo_d   = ld_addr_lo;
               end else begin
                  rf_we_d    = (dec_dest != '0);
                  rf_waddr_d = dec_dest;
                  rf_wdata_d = (dec_sel == SELECT_WB_LINK) ? link_pc : alu_res;
               end
            end
         end
         default: begin
            if (flush) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else if (ld_valid) begin
               // data arriving on the timeout cycle still wins
               rf_we_d    = (ld_dest_q != '0);
               rf_waddr_d = ld_dest_q;
               rf_wdata_d = ld_aligned;
               state_d    = S_IDLE;
               cnt_d      = '0;
            end else if (cnt_inc == CNT_W'(LOAD_TIMEOUT)) begin
               ld_err_d = 1'b1;
               state_d  = S_IDLE;
               cnt_d    = '0;
            end else begin
               cnt_d = cnt_inc;
            end
         end
      endcase
   end

   // State and output registers; reset abandons any pending load without writing.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         ld_dest_q  <= '0;
         ld_size_q  <= LD_WORD;
         ld_uns_q   <= 1'b0;
         ld_lo_q    <= '0;
         rf_we_q    <= 1'b0;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
         ld_err_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         ld_dest_q  <= ld_dest_d;
         ld_size_q  <= ld_size_d;
         ld_uns_q   <= ld_uns_d;
         ld_lo_q    <= ld_lo_d;
         rf_we_q    <= rf_we_d;
         rf_waddr_q <= rf_waddr_d;
         rf_wdata_q <= rf_wdata_d;
         ld_err_q   <= ld_err_d;
      end
   end

   assign in_ready   = (state_q == S_IDLE);
   assign pend_valid = (state_q == S_WAIT_LOAD);
   assign pend_rd    = pend_valid ? ld_dest_q : '0;
   assign rf_we      = rf_we_q;
   assign rf_waddr   = rf_waddr_q;
   assign rf_wdata   = rf_wdata_q;
   assign ld_err     = ld_err_q;

endmodule

// File: tb/tb_wb_ctrl_pipe.sv
// Scoreboard bench for wb_ctrl_pipe: stimulus queues expected RF writes, monitor pops on rf_we.
// Latency: expects writes one cycle after acceptance / ld_valid.
// Backpressure: honours in_ready by only issuing when the stage is idle.
module tb_wb_ctrl_pipe;

   logic        CLK = 1'b0;
   logic        RESET_N = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] IR = '0;
   logic [31:0] alu_res = '0;
   logic [31:0] link_pc = '0;
   logic [1:0]  ld_addr_lo = '0;
   logic        ld_valid = 1'b0;
   logic [31:0] ld_data = '0;
   logic        flush = 1'b0;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        pend_valid;
   logic [4:0]  pend_rd;
   logic        ld_err;

   wb_ctrl_pipe dut (
      .CLK        (CLK),
      .RESET_N    (RESET_N),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .IR         (IR),
      .alu_res    (alu_res),
      .link_pc    (link_pc),
      .ld_addr_lo (ld_addr_lo),
      .ld_valid   (ld_valid),
      .ld_data    (ld_data),
      .flush      (flush),
      .rf_we      (rf_we),
      .rf_waddr   (rf_waddr),
      .rf_wdata   (rf_wdata),
      .pend_valid (pend_valid),
      .pend_rd    (pend_rd),
      .ld_err     (ld_err)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic [4:0]  addr;
      logic [31:0] data;
   } wr_t;

   wr_t exp_q[$];
   int  errors = 0;
   int  checks = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] fn);
      return {6'h00, rs, rt, rd, 5'd0, fn};
   endfunction

   function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
      wr_t w;
      w.addr = a;
      w.data = d;
      exp_q.push_back(w);
   endtask

   // Present one non-load instruction for a single cycle (caller ends with idle()).
   task automatic issue(input logic [31:0] ir, input logic [31:0] alu, input logic [31:0] lpc,
                        input logic fl, input logic ew, input logic [4:0] ea, input logic [31:0] ed);
      @(negedge CLK);
      IR = ir; alu_res = alu; link_pc = lpc; flush = fl; in_valid = 1'b1;
      if (ew) expect_wr(ea, ed);
   endtask

   task automatic idle();
      @(negedge CLK);
      in_valid = 1'b0; flush = 1'b0; IR = '0;
   endtask

   // Issue a load, return data in the delay-th wait cycle, check pending/ready handshake.
   task automatic do_load(input logic [31:0] ir, input logic [1:0] lo, input int delay,
                          input logic [31:0] data, input logic [4:0] rt,
                          input logic ew, input logic [31:0] ed);
      @(negedge CLK);
      IR = ir; in_valid = 1'b1; ld_addr_lo = lo;
      @(negedge CLK);
      in_valid = 1'b0; IR = '0; ld_addr_lo = ~lo;
      chk("pend_valid_wait", pend_valid, 1);
      chk("pend_rd_wait", pend_rd, rt);
      chk("in_ready_wait", in_ready, 0);
      repeat (delay - 1) @(negedge CLK);
      ld_valid = 1'b1; ld_data = data;
      if (ew) expect_wr(rt, ed);
      @(negedge CLK);
      ld_valid = 1'b0; ld_data = '0;
      chk("pend_valid_done", pend_valid, 0);
      chk("in_ready_done", in_ready, 1);
   endtask

   // Monitor: every observed write must match the oldest queued expectation.
   initial begin
      wr_t e;
      forever begin
         @(negedge CLK);
         if (rf_we === 1'b1) begin
            if (exp_q.size() == 0) begin
               chk("spurious_write_addr", {27'd0, rf_waddr}, 32'hFFFF_FFFF);
            end else begin
               e = exp_q.pop_front();
               chk("wb_addr", {27'd0, rf_waddr}, {27'd0, e.addr});
               chk("wb_data", rf_wdata, e.data);
            end
         end
      end
   end

   initial begin
      #1 RESET_N = 1'b0;
      #1;
      chk("rst_rf_we", rf_we, 0);
      chk("rst_rf_waddr", rf_waddr, 0);
      chk("rst_rf_wdata", rf_wdata, 0);
      chk("rst_pend_valid", pend_valid, 0);
      chk("rst_pend_rd", pend_rd, 0);
      chk("rst_ld_err", ld_err, 0);
      repeat (3) @(negedge CLK);
      RESET_N = 1'b1;
      @(negedge CLK);
      chk("rst_in_ready", in_ready, 1);

      // ALU, link and store paths
      issue(rtype(5'd1, 5'd2, 5'd3, 6'h20), 32'h1234, 32'h0, 1'b0, 1'b1, 5'd3, 32'h1234);
      idle();
      chk("in_ready_after_add", in_ready, 1);
      issue(32'h0C00_0040, 32'hDEAD, 32'h108, 1'b0, 1'b1, 5'd31, 32'h108);
      idle();
      issue(rtype(5'd4, 5'd0, 5'd5, 6'h09), 32'h55, 32'h200, 1'b0, 1'b1, 5'd5, 32'h200);
      idle();
      issue(itype(6'h2B, 5'd1, 5'd9, 16'h10), 32'h77, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
      idle();
      issue(itype(6'h08, 5'd1, 5'd0, 16'h5), 32'h5, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
      idle();
      issue(itype(6'h08, 5'd1, 5'd4, 16'h5), 32'hCAFE, 32'h0, 1'b0, 1'b1, 5'd4, 32'hCAFE);
      idle();

      // back-to-back, then a flushed instruction that must not write
      issue(rtype(5'd1, 5'd2, 5'd3, 6'h21), 32'hA1, 32'h0, 1'b0, 1'b1, 5'd3, 32'hA1);
      issue(itype(6'h0D, 5'd2, 5'd4, 16'h1), 32'hA2, 32'h0, 1'b0, 1'b1, 5'd4, 32'hA2);
      issue(rtype(5'd1, 5'd2, 5'd6, 6'h20), 32'hA3, 32'h0, 1'b1, 1'b0, 5'd0, 32'h0);
      idle();

      // stray ld_valid while idle is ignored
      @(negedge CLK); ld_valid = 1'b1; ld_data = 32'hFFFF_FFFF;
      @(negedge CLK); ld_valid = 1'b0; ld_data = '0;

      // loads: lanes and extension
      do_load(itype(6'h20, 5'd1, 5'd7, 16'h1), 2'd1, 3, 32'h11F2_3344, 5'd7, 1'b1, 32'hFFFF_FFF2);
      do_load(itype(6'h24, 5'd1, 5'd7, 16'h1), 2'd1, 3, 32'h11F2_3344, 5'd7, 1'b1, 32'h0000_00F2);
      do_load(itype(6'h20, 5'd1, 5'd9, 16'h3), 2'd3, 1, 32'h1122_337F, 5'd9, 1'b1, 32'h0000_007F);
      do_load(itype(6'h21, 5'd1, 5'd10, 16'h2), 2'd2, 2, 32'h11F2_8344, 5'd10, 1'b1, 32'hFFFF_8344);
      do_load(itype(6'h25, 5'd1, 5'd11, 16'h0), 2'd0, 4, 32'h8ABC_1234, 5'd11, 1'b1, 32'h0000_8ABC);
      do_load(itype(6'h23, 5'd1, 5'd0, 16'h0), 2'd0, 2, 32'h1357_9BDF, 5'd0, 1'b0, 32'h0);

      // data on the final allowed wait cycle beats the timeout
      do_load(itype(6'h23, 5'd1, 5'd13, 16'h0), 2'd2, 15, 32'h0BAD_F00D, 5'd13, 1'b1, 32'h0BAD_F00D);
      chk("no_err_data_at_limit", ld_err, 0);

      // timeout: 15 wait cycles without data
      @(negedge CLK); IR = itype(6'h23, 5'd1, 5'd8, 16'h0); in_valid = 1'b1;
      @(negedge CLK); in_valid = 1'b0; IR = '0;
      repeat (14) @(negedge CLK);
      chk("err_before_limit", ld_err, 0);
      chk("pend_before_limit", pend_valid, 1);
      @(negedge CLK);
      chk("err_at_limit", ld_err, 1);
      chk("pend_after_timeout", pend_valid, 0);
      chk("ready_after_timeout", in_ready, 1);
      do_load(itype(6'h23, 5'd1, 5'd12, 16'h0), 2'd3, 2, 32'hDEAD_BEEF, 5'd12, 1'b1, 32'hDEAD_BEEF);
      chk("err_sticky", ld_err, 1);

      // flush with simultaneous ld_valid while waiting
      @(negedge CLK); IR = itype(6'h23, 5'd1, 5'd14, 16'h0); in_valid = 1'b1;
      @(negedge CLK); in_valid = 1'b0; IR = '0;
      @(negedge CLK); flush = 1'b1; ld_valid = 1'b1; ld_data = 32'h1234_5678;
      @(negedge CLK); flush = 1'b0; ld_valid = 1'b0; ld_data = '0;
      chk("flush_pend_clear", pend_valid, 0);
      chk("flush_ready", in_ready, 1);
      repeat (2) @(negedge CLK);

      // asynchronous reset in the middle of a wait
      @(negedge CLK); IR = itype(6'h23, 5'd1, 5'd15, 16'h0); in_valid = 1'b1;
      @(negedge CLK); in_valid = 1'b0; IR = '0;
      @(negedge CLK);
      #2 RESET_N = 1'b0;
      #1;
      chk("mid_rst_rf_we", rf_we, 0);
      chk("mid_rst_rf_waddr", rf_waddr, 0);
      chk("mid_rst_rf_wdata", rf_wdata, 0);
      chk("mid_rst_pend_valid", pend_valid, 0);
      chk("mid_rst_pend_rd", pend_rd, 0);
      chk("mid_rst_ld_err", ld_err, 0);
      ld_valid = 1'b1; ld_data = 32'hAAAA_5555;
      @(negedge CLK); RESET_N = 1'b1; ld_valid = 1'b0; ld_data = '0;
      chk("post_rst_ready", in_ready, 1);

      // normal operation resumes
      issue(rtype(5'd1, 5'd2, 5'd3, 6'h20), 32'h77, 32'h0, 1'b0, 1'b1, 5'd3, 32'h77);
      idle();
      repeat (3) @(negedge CLK);
      chk("scoreboard_drained", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
